// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: address/instruction widths, fetch FSM states and
// the prefetch queue entry layout.
package cpu_pkg;

    localparam int unsigned PC_W    = 12;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        Boot,
        Run,
        Flush
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Program-memory read port, branch redirect and decode handshake of the fetch
// stage. The fetch unit drives through master; memory/decode sit on slave.
interface instr_fetch_queue_if #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = 12,
    parameter int unsigned INSTR_W = 16
);
    localparam int unsigned LvlW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]    mem_addr;
    logic               mem_rd_en;
    logic [INSTR_W-1:0] mem_rdata;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic [LvlW-1:0]    level;

    modport master (
        output mem_addr, mem_rd_en, instr_valid, instr, instr_pc, level,
        input  mem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_addr, mem_rd_en, instr_valid, instr, instr_pc, level,
        output mem_rdata, redirect, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of PC-tagged instructions. Flush wins over push and pop; the
// head is presented from registered storage with no push-to-head bypass.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  fetch_entry_t    push_data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output fetch_entry_t    head_o,
    output logic [CntW-1:0] count_o
);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CntW'(push_i) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    // The fetch credit scheme must never let a push land on a full queue.
    push_when_full_a: assert property (@(posedge clk) disable iff (!reset)
        !(push_i && !flush_i && (count_q == CntW'(DEPTH))));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one program-memory read per cycle
// while credit allows, and queues returned instructions for decode.
module instr_fetch_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = 12,
    parameter int unsigned INSTR_W = 16
) (
    input logic                 clk,
    input logic                 reset,
    instr_fetch_queue_if.master fq_io
);
    import cpu_pkg::*;

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] issued_pc_q, issued_pc_d;
    logic            pending_q, pending_d;
    logic            kill_q, kill_d;
    logic            issue, push, pop;
    logic [CntW-1:0] count;
    logic [CntW:0]   inflight;
    fetch_entry_t    push_entry, head;

    // Credit counts reads still in flight so a stalled consumer never overflows.
    assign inflight = {1'b0, count} + {{CntW{1'b0}}, pending_q};

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        pending_d   = 1'b0;
        kill_d      = 1'b0;
        issue       = 1'b0;
        unique case (state_q)
            Boot:    state_d = Run;
            Run:     issue   = (inflight < (CntW + 1)'(DEPTH));
            Flush:   state_d = Run;
            default: state_d = Boot;
        endcase
        if (fq_io.redirect) begin
            state_d    = Flush;
            issue      = 1'b0;
            fetch_pc_d = fq_io.redirect_pc;
            kill_d     = 1'b1;
        end else if (issue) begin
            pending_d   = 1'b1;
            issued_pc_d = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= Boot;
            fetch_pc_q  <= '0;
            issued_pc_q <= '0;
            pending_q   <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            pending_q   <= pending_d;
            kill_q      <= kill_d;
        end
    end

    // A response landing in the redirect cycle belongs to the abandoned path.
    assign push             = pending_q && !kill_q && !fq_io.redirect;
    assign pop              = fq_io.instr_valid && fq_io.instr_ready;
    assign push_entry.instr = fq_io.mem_rdata;
    assign push_entry.pc    = issued_pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (fq_io.redirect),
        .head_o      (head),
        .count_o     (count)
    );

    assign fq_io.mem_rd_en   = issue;
    assign fq_io.mem_addr    = fetch_pc_q;
    assign fq_io.instr_valid = (count != '0);
    assign fq_io.instr       = INSTR_W'(head.instr);
    assign fq_io.instr_pc    = head.pc;
    assign fq_io.level       = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed timing checks plus a random
// ready/redirect run, with delivered instructions checked against a PC stream.
module tb_instr_fetch_queue;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          pops     = 0;
    int          p0       = 0;
    logic [11:0] exp_pc   = '0;

    instr_fetch_queue_if #(.DEPTH(4), .PC_W(12), .INSTR_W(16)) fq ();

    instr_fetch_queue #(
        .DEPTH   (4),
        .PC_W    (12),
        .INSTR_W (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fq_io (fq)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: word at address k holds 16'hA000 + k.
    always @(posedge clk) begin
        if (fq.mem_rd_en) fq.mem_rdata <= 16'hA000 + 16'(fq.mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every delivered instruction must be the next PC of the current stream.
    task automatic step();
        if (fq.instr_valid && fq.instr_ready) begin
            chk("pop_pc", 32'(fq.instr_pc), 32'(exp_pc));
            chk("pop_instr", 32'(fq.instr), 32'(16'hA000 + 16'(exp_pc)));
            exp_pc = exp_pc + 12'd1;
            pops++;
        end
        if (fq.redirect) exp_pc = fq.redirect_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(fq.mem_rd_en), 0);
        chk({tag, "_addr"}, 32'(fq.mem_addr), 0);
        chk({tag, "_valid"}, 32'(fq.instr_valid), 0);
        chk({tag, "_instr"}, 32'(fq.instr), 0);
        chk({tag, "_pc"}, 32'(fq.instr_pc), 0);
        chk({tag, "_level"}, 32'(fq.level), 0);
    endtask

    initial begin
        fq.redirect    = 1'b0;
        fq.redirect_pc = '0;
        fq.instr_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");

        // Boot sequence: cycle 0 idle, reads from 0, first valid at cycle 3.
        reset = 1'b1;
        chk("boot_rd_en", 32'(fq.mem_rd_en), 0);
        step();
        chk("c1_rd_en", 32'(fq.mem_rd_en), 1);
        chk("c1_addr", 32'(fq.mem_addr), 0);
        chk("c1_valid", 32'(fq.instr_valid), 0);
        step();
        chk("c2_addr", 32'(fq.mem_addr), 1);
        chk("c2_valid", 32'(fq.instr_valid), 0);
        step();
        chk("c3_valid", 32'(fq.instr_valid), 1);
        chk("c3_pc", 32'(fq.instr_pc), 0);
        chk("c3_instr", 32'(fq.instr), 32'h0000A000);
        p0 = pops;
        repeat (6) step();
        chk("stream_rate", 32'(pops - p0), 6);

        // Consumer stall: queue fills to DEPTH and reads stop.
        fq.instr_ready = 1'b0;
        repeat (10) begin
            step();
            chk("stall_level_max", 32'(fq.level <= 3'd4), 1);
        end
        chk("stall_level", 32'(fq.level), 4);
        chk("stall_no_read", 32'(fq.mem_rd_en), 0);
        fq.instr_ready = 1'b1;
        repeat (8) step();

        // Redirect with two queued entries and a response in flight.
        chk("pre_redir_level", 32'(fq.level), 2);
        fq.instr_ready = 1'b0;
        fq.redirect    = 1'b1;
        fq.redirect_pc = 12'h100;
        #1;
        chk("redir_no_read", 32'(fq.mem_rd_en), 0);
        step();
        fq.redirect    = 1'b0;
        fq.instr_ready = 1'b1;
        chk("flush_level", 32'(fq.level), 0);
        chk("flush_valid", 32'(fq.instr_valid), 0);
        chk("flush_no_read", 32'(fq.mem_rd_en), 0);
        step();
        chk("r2_rd_en", 32'(fq.mem_rd_en), 1);
        chk("r2_addr", 32'(fq.mem_addr), 32'h100);
        step();
        chk("r3_valid", 32'(fq.instr_valid), 0);
        step();
        chk("r4_valid", 32'(fq.instr_valid), 1);
        chk("r4_pc", 32'(fq.instr_pc), 32'h100);

        // Fetch PC wraps from FFF to 000.
        fq.redirect    = 1'b1;
        fq.redirect_pc = 12'hFFE;
        step();
        fq.redirect = 1'b0;
        repeat (3) step();
        chk("wrap_pc0", 32'(fq.instr_pc), 32'hFFE);
        step();
        chk("wrap_pc1", 32'(fq.instr_pc), 32'hFFF);
        step();
        chk("wrap_pc2", 32'(fq.instr_pc), 32'h000);
        step();
        chk("wrap_pc3", 32'(fq.instr_pc), 32'h001);
        chk("wrap_valid", 32'(fq.instr_valid), 1);

        // Asynchronous reset mid-stream with level 3 and a read outstanding.
        fq.instr_ready = 1'b0;
        step();
        step();
        chk("pre_rst_level", 32'(fq.level), 3);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        exp_pc = '0;
        @(posedge clk);
        #1;
        reset          = 1'b1;
        fq.instr_ready = 1'b1;
        chk("rb_boot_rd_en", 32'(fq.mem_rd_en), 0);
        step();
        chk("rb_c1_addr", 32'(fq.mem_addr), 0);
        chk("rb_c1_valid", 32'(fq.instr_valid), 0);
        step();
        chk("rb_c2_valid", 32'(fq.instr_valid), 0);
        step();
        chk("rb_c3_pc", 32'(fq.instr_pc), 0);
        chk("rb_c3_valid", 32'(fq.instr_valid), 1);

        // Redirect together with a pop, then a second redirect during FLUSH.
        repeat (3) step();
        chk("pre_dual_valid", 32'(fq.instr_valid), 1);
        p0             = pops;
        fq.redirect    = 1'b1;
        fq.redirect_pc = 12'h150;
        step();
        fq.redirect_pc = 12'h200;
        step();
        fq.redirect = 1'b0;
        chk("dual_flush_rd", 32'(fq.mem_rd_en), 0);
        step();
        chk("dual_rd_en", 32'(fq.mem_rd_en), 1);
        chk("dual_addr", 32'(fq.mem_addr), 32'h200);
        step();
        chk("dual_pops", 32'(pops - p0), 1);
        chk("dual_valid_gap", 32'(fq.instr_valid), 0);
        step();
        chk("dual_valid", 32'(fq.instr_valid), 1);
        chk("dual_pc", 32'(fq.instr_pc), 32'h200);

        // Random consumer back-pressure and redirects.
        p0 = pops;
        for (int i = 0; i < 400; i++) begin
            fq.instr_ready = ($urandom_range(0, 3) != 0);
            fq.redirect    = ($urandom_range(0, 15) == 0);
            fq.redirect_pc = 12'($urandom);
            chk("rand_level_max", 32'(fq.level <= 3'd4), 1);
            chk("rand_valid_level", 32'(fq.instr_valid), 32'(fq.level != 3'd0));
            step();
        end
        fq.redirect = 1'b0;
        chk("rand_progress", 32'(pops - p0 > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
